// File: rtl/orch85_sdm_audio.sv
// orch85_sdm_audio
// Audio output stage for Orchestra-85 samples plus the cassette port level.
// Each channel mixes its active sample with the cassette contribution, then
// drives a first-order sigma-delta modulator that runs once per tick.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   orch_l_wr   one-cycle strobe, orch_data -> left pending sample
//   orch_r_wr   one-cycle strobe, orch_data -> right pending sample
//   orch_data   signed 8-bit sample from the TRS data bus
//   cass_level  cassette port bits [1:0]
//   audio_l     left 1-bit sigma-delta stream
//   audio_r     right 1-bit sigma-delta stream
//   tick        one-cycle pulse marking a modulator update
//
// Optional build macro ORCH85_IDLE_MUTE_EN: after IDLE_TICKS ticks without a
// sample write, both outputs are forced low and the accumulators held at 0
// until the next write.
module orch85_sdm_audio #(
    parameter int TICK_DIV   = 4,
    parameter int CASS_AMPL  = 64,
    parameter int IDLE_TICKS = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       orch_l_wr,
    input  logic       orch_r_wr,
    input  logic [7:0] orch_data,
    input  logic [1:0] cass_level,
    output logic       audio_l,
    output logic       audio_r,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [7:0]        act_l_q, act_l_d, act_r_q, act_r_d;
    logic signed [9:0] cass_val_q, cass_val_d;
    logic [7:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic              aud_l_q, aud_l_d, aud_r_q, aud_r_d;
    logic [7:0]        u_l, u_r;
    logic [8:0]        mod_l, mod_r;
    logic              mute;

    // Saturating mix to [-128, 127], then offset to unsigned by flipping the sign bit.
    function automatic logic [7:0] mix_u(input logic [7:0] a, input logic signed [9:0] c);
        logic signed [9:0] s;
        logic [7:0]        sat;
        s = $signed({{2{a[7]}}, a}) + c;
        if (s > 10'sd127)
            sat = 8'h7F;
        else if (s < -10'sd128)
            sat = 8'h80;
        else
            sat = s[7:0];
        return {~sat[7], sat[6:0]};
    endfunction

    assign tick  = (cnt_q == CW'(TICK_DIV - 1));
    assign u_l   = mix_u(act_l_q, cass_val_q);
    assign u_r   = mix_u(act_r_q, cass_val_q);
    assign mod_l = {1'b0, acc_l_q} + {1'b0, u_l};
    assign mod_r = {1'b0, acc_r_q} + {1'b0, u_r};

`ifdef ORCH85_IDLE_MUTE_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);

    logic [IW-1:0] idle_q, idle_d;

    // Counter stops at IDLE_TICKS, which is also the mute condition.
    assign mute = (idle_q == IW'(IDLE_TICKS));

    always_comb begin
        idle_d = idle_q;
        if (orch_l_wr || orch_r_wr)
            idle_d = '0;
        else if (tick && !mute)
            idle_d = idle_q + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    // IDLE_TICKS only matters when idle mute is built in.
    logic unused_idle_ticks;
    assign unused_idle_ticks = (IDLE_TICKS != 0);
    assign mute = 1'b0;
`endif

    // Gating the registered bit makes mute take effect on the very cycle the
    // idle limit is reached.
    assign audio_l = aud_l_q & ~mute;
    assign audio_r = aud_r_q & ~mute;

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        pend_l_d   = orch_l_wr ? orch_data : pend_l_q;
        pend_r_d   = orch_r_wr ? orch_data : pend_r_q;
        act_l_d    = act_l_q;
        act_r_d    = act_r_q;
        cass_val_d = cass_val_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        aud_l_d    = aud_l_q;
        aud_r_d    = aud_r_q;

        if (tick) begin
            // A write landing on the tick bypasses the pending register.
            act_l_d = orch_l_wr ? orch_data : pend_l_q;
            act_r_d = orch_r_wr ? orch_data : pend_r_q;
            case (cass_level)
                2'b01:   cass_val_d = 10'(CASS_AMPL);
                2'b10:   cass_val_d = 10'(-CASS_AMPL);
                default: cass_val_d = '0;
            endcase
            // Modulates with the sample loaded on the previous tick.
            acc_l_d = mod_l[7:0];
            acc_r_d = mod_r[7:0];
            aud_l_d = mod_l[8];
            aud_r_d = mod_r[8];
        end

        if (mute) begin
            acc_l_d = '0;
            acc_r_d = '0;
            aud_l_d = 1'b0;
            aud_r_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            pend_l_q   <= '0;
            pend_r_q   <= '0;
            act_l_q    <= '0;
            act_r_q    <= '0;
            cass_val_q <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            aud_l_q    <= 1'b0;
            aud_r_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            act_l_q    <= act_l_d;
            act_r_q    <= act_r_d;
            cass_val_q <= cass_val_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            aud_l_q    <= aud_l_d;
            aud_r_q    <= aud_r_d;
        end
    end

endmodule

// File: tb/tb_orch85_sdm_audio.sv
// tb_orch85_sdm_audio
// Self-checking bench for orch85_sdm_audio with TICK_DIV=4, CASS_AMPL=64,
// IDLE_TICKS=8. Expected per-tick output bits are derived from the sample
// values and pushed to a queue when stimulus is applied; each tick's
// registered output is popped and compared half a clock after the update.
module tb_orch85_sdm_audio;

    localparam int TICK_DIV   = 4;
    localparam int CASS_AMPL  = 64;
    localparam int IDLE_TICKS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       orch_l_wr = 1'b0;
    logic       orch_r_wr = 1'b0;
    logic [7:0] orch_data = 8'h00;
    logic [1:0] cass_level = 2'b00;
    logic       audio_l, audio_r, tick;

    int vectors = 0;
    int miscompares = 0;
    bit [1:0] exp_q[$];

    orch85_sdm_audio #(
        .TICK_DIV  (TICK_DIV),
        .CASS_AMPL (CASS_AMPL),
        .IDLE_TICKS(IDLE_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .orch_l_wr (orch_l_wr),
        .orch_r_wr (orch_r_wr),
        .orch_data (orch_data),
        .cass_level(cass_level),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Unsigned modulator input for a signed sample plus cassette term.
    function automatic int exp_u(input int d, input int c);
        int s;
        s = d + c;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s + 128;
    endfunction

    // Expected {audio_l, audio_r} for n ticks starting from zero accumulators:
    // first tick uses x1, second x2, the rest x3.
    function automatic void push_stream(input int l1, input int l2, input int l3,
                                        input int r1, input int r2, input int r3,
                                        input int n);
        int al, ar, ul, ur;
        bit cl, cr;
        al = 0;
        ar = 0;
        for (int k = 0; k < n; k++) begin
            ul = (k == 0) ? l1 : (k == 1) ? l2 : l3;
            ur = (k == 0) ? r1 : (k == 1) ? r2 : r3;
            al = al + ul;
            ar = ar + ur;
            cl = (al >= 256);
            cr = (ar >= 256);
            al = al % 256;
            ar = ar % 256;
            exp_q.push_back({cl, cr});
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        orch_l_wr = 1'b0;
        orch_r_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_write(input bit l, input bit r, input logic [7:0] d);
        orch_l_wr = l;
        orch_r_wr = r;
        orch_data = d;
        @(negedge clk);
        orch_l_wr = 1'b0;
        orch_r_wr = 1'b0;
    endtask

    // Advance to the negedge of a cycle in which tick is high.
    task automatic goto_tick();
        int n;
        n = 0;
        while (tick !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 4 * TICK_DIV) begin
                $display("FAIL tick_timeout: no tick within %0d cycles", n);
                $fatal(1, "tick never asserted");
            end
        end
    endtask

    task automatic tick_sample(output bit [1:0] a);
        goto_tick();
        @(negedge clk);
        a = {audio_l, audio_r};
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (audio_l !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_audio_l: got %b expected 0", audio_l);
        end
        vectors++;
        if (audio_r !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_audio_r: got %b expected 0", audio_r);
        end
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            vectors++;
            if (tick !== ((i % TICK_DIV) == TICK_DIV - 1)) begin
                miscompares++;
                $display("FAIL tick_period cycle %0d: got %b expected %b",
                         i, tick, ((i % TICK_DIV) == TICK_DIV - 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle_pattern();
        bit [1:0] got, exp;
        exp_q.delete();
        cass_level = 2'b00;
        apply_reset();
        push_stream(128, 128, 128, 128, 128, 128, 16);
        for (int k = 0; k < 16; k++) begin
            tick_sample(got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL idle_pattern tick %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_left_min();
        bit [1:0] got, exp;
        int ones_l;
        exp_q.delete();
        cass_level = 2'b00;
        apply_reset();
        pulse_write(1'b1, 1'b0, 8'h80);
        push_stream(128, exp_u(-128, 0), exp_u(-128, 0), 128, 128, 128, 513);
        ones_l = 0;
        for (int k = 0; k < 513; k++) begin
            tick_sample(got);
            if (k >= 1) ones_l += got[1];
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL left_min tick %0d: got %b expected %b", k, got, exp);
            end
        end
        vectors++;
        if (ones_l !== 0) begin
            miscompares++;
            $display("FAIL left_min_density: got %0d ones expected 0", ones_l);
        end
    endtask

    task automatic test_right_max_cass();
        bit [1:0] got, exp;
        int ones_l, ones_r;
        exp_q.delete();
        apply_reset();
        cass_level = 2'b01;
        pulse_write(1'b0, 1'b1, 8'h7F);
        push_stream(128, exp_u(0, CASS_AMPL), exp_u(0, CASS_AMPL),
                    128, exp_u(127, CASS_AMPL), exp_u(127, CASS_AMPL), 257);
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 257; k++) begin
            tick_sample(got);
            if (k >= 1) begin
                ones_l += got[1];
                ones_r += got[0];
            end
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL right_max tick %0d: got %b expected %b", k, got, exp);
            end
        end
        // 256 ticks from acc=128: u=255 -> 255 ones, u=192 -> 192 ones.
        vectors++;
        if (ones_r !== 255) begin
            miscompares++;
            $display("FAIL right_max_density: got %0d ones expected 255", ones_r);
        end
        vectors++;
        if (ones_l !== 192) begin
            miscompares++;
            $display("FAIL left_cass_density: got %0d ones expected 192", ones_l);
        end
        cass_level = 2'b00;
    endtask

    task automatic test_back_to_back();
        bit [1:0] got, exp;
        int ones_l;
        exp_q.delete();
        cass_level = 2'b00;
        apply_reset();
        pulse_write(1'b1, 1'b0, 8'h10);
        pulse_write(1'b1, 1'b0, 8'h20);
        push_stream(128, exp_u(32, 0), exp_u(48, 0), 128, 128, 128, 258);
        ones_l = 0;
        for (int k = 0; k < 258; k++) begin
            if (k == 1) begin
                goto_tick();
                orch_l_wr = 1'b1;
                orch_data = 8'h30;
                @(negedge clk);
                orch_l_wr = 1'b0;
                got = {audio_l, audio_r};
            end else begin
                tick_sample(got);
            end
            if (k >= 2) ones_l += got[1];
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back tick %0d: got %b expected %b", k, got, exp);
            end
        end
        vectors++;
        if (ones_l !== 176) begin
            miscompares++;
            $display("FAIL bypass_density: got %0d ones expected 176", ones_l);
        end
    endtask

    task automatic test_reset_midstream();
        bit [1:0] got, exp;
        exp_q.delete();
        apply_reset();
        cass_level = 2'b01;
        pulse_write(1'b1, 1'b1, 8'h7F);
        for (int k = 0; k < 6; k++) tick_sample(got);
        pulse_write(1'b1, 1'b0, 8'h90);
        cass_level = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({audio_l, audio_r, tick} !== 3'b000) begin
            miscompares++;
            $display("FAIL midstream_reset: got %b expected 000", {audio_l, audio_r, tick});
        end
        push_stream(128, 128, 128, 128, 128, 128, 16);
        for (int k = 0; k < 16; k++) begin
            tick_sample(got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midstream_restart tick %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

`ifdef ORCH85_IDLE_MUTE_EN
    task automatic test_idle_mute();
        bit [1:0] got, exp;
        exp_q.delete();
        cass_level = 2'b00;
        apply_reset();
        pulse_write(1'b1, 1'b0, 8'h40);
        push_stream(128, exp_u(64, 0), exp_u(64, 0), 128, 128, 128, IDLE_TICKS - 1);
        for (int k = 0; k < 5; k++) exp_q.push_back(2'b00);
        for (int k = 0; k < IDLE_TICKS + 4; k++) begin
            tick_sample(got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mute_entry tick %0d: got %b expected %b", k, got, exp);
            end
        end
        pulse_write(1'b1, 1'b0, 8'h00);
        push_stream(exp_u(64, 0), 128, 128, 128, 128, 128, 6);
        for (int k = 0; k < 6; k++) begin
            tick_sample(got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mute_resume tick %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_pattern();
        test_left_min();
        test_right_max_cass();
        test_back_to_back();
        test_reset_midstream();
`ifdef ORCH85_IDLE_MUTE_EN
        test_idle_mute();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
